collision_scheduler: RTL and testbench

Frame-level collision controller for the 160x120 playfield. On `start` it snapshots all bullet and asteroid positions. It then drives one shared pair-check datapath through every bullet/asteroid pair, one pair per clock. At the end it reports per-object hit masks and a hit count to game logic. The renderer then removes hit objects.

---
 rtl/collision_pkg.sv | 20 ++
 rtl/pair_hit_checker.sv | 53 +++++
 rtl/collision_scheduler.sv | 139 +++++++++++++
 tb/tb_collision_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared constants, FSM state type and width helper for the collision scheduler.
package collision_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int DEF_XW   = 8;
  localparam int DEF_YW   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int count_width(input int num_pairs);
    return $clog2(num_pairs + 1);
  endfunction

endpackage

// File: rtl/pair_hit_checker.sv
// Registered bullet-in-asteroid box test for a single pair, with a pass-through pair tag.
module pair_hit_checker
  import collision_pkg::*;
#(
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int AST_SIZE = 8,
  parameter int TW       = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [XW-1:0] bx,
  input  logic [YW-1:0] by,
  input  logic          bvalid,
  input  logic [XW-1:0] ax,
  input  logic [YW-1:0] ay,
  input  logic          avalid,
  input  logic [TW-1:0] in_tag,
  output logic          hit,
  output logic          out_valid,
  output logic [TW-1:0] tag
);

  // One extra bit so the far box edge never wraps at the playfield border.
  logic [XW:0] bx_e, ax_lo, ax_hi;
  logic [YW:0] by_e, ay_lo, ay_hi;
  logic        hit_c;

  assign bx_e  = {1'b0, bx};
  assign ax_lo = {1'b0, ax};
  assign ax_hi = ax_lo + (XW+1)'(AST_SIZE);
  assign by_e  = {1'b0, by};
  assign ay_lo = {1'b0, ay};
  assign ay_hi = ay_lo + (YW+1)'(AST_SIZE);

  assign hit_c = bvalid && avalid &&
                 (bx_e >= ax_lo) && (bx_e < ax_hi) &&
                 (by_e >= ay_lo) && (by_e < ay_hi);

  always_ff @(posedge clock) begin
    if (reset) begin
      hit       <= 1'b0;
      out_valid <= 1'b0;
      tag       <= '0;
    end else begin
      hit       <= in_valid && hit_c;
      out_valid <= in_valid;
      tag       <= in_tag;
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// Frame collision controller: snapshots objects on start, walks every bullet/asteroid
// pair through one shared checker, and accumulates hit masks and a pair count.
//
// state | meaning
// IDLE  | waiting for start; results from the last scan held
// SCAN  | issuing one (bullet, asteroid) pair per clock
// DRAIN | collecting the final checker result
// DONE  | one-cycle done pulse, results final
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int NUM_BULLETS   = 8,
  parameter int NUM_ASTEROIDS = 8,
  parameter int XW            = DEF_XW,
  parameter int YW            = DEF_YW,
  parameter int AST_SIZE      = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [NUM_BULLETS*XW-1:0]              bullet_x,
  input  logic [NUM_BULLETS*YW-1:0]              bullet_y,
  input  logic [NUM_BULLETS-1:0]                 bullet_valid,
  input  logic [NUM_ASTEROIDS*XW-1:0]            ast_x,
  input  logic [NUM_ASTEROIDS*YW-1:0]            ast_y,
  input  logic [NUM_ASTEROIDS-1:0]               ast_valid,
  output logic                                   busy,
  output logic                                   done,
  output logic [NUM_BULLETS-1:0]                 bullet_hit,
  output logic [NUM_ASTEROIDS-1:0]               ast_hit,
  output logic [count_width(NUM_BULLETS*NUM_ASTEROIDS)-1:0] hit_count
);

  localparam int BW  = (NUM_BULLETS   > 1) ? $clog2(NUM_BULLETS)   : 1;
  localparam int AW  = (NUM_ASTEROIDS > 1) ? $clog2(NUM_ASTEROIDS) : 1;
  localparam int TW  = BW + AW;
  localparam int HCW = count_width(NUM_BULLETS*NUM_ASTEROIDS);
  localparam logic [BW-1:0] BI_LAST = BW'(NUM_BULLETS-1);
  localparam logic [AW-1:0] AJ_LAST = AW'(NUM_ASTEROIDS-1);

  state_e state;
  logic [BW-1:0] bi;
  logic [AW-1:0] aj;

  logic [NUM_BULLETS*XW-1:0]   snap_bx;
  logic [NUM_BULLETS*YW-1:0]   snap_by;
  logic [NUM_BULLETS-1:0]      snap_bv;
  logic [NUM_ASTEROIDS*XW-1:0] snap_ax;
  logic [NUM_ASTEROIDS*YW-1:0] snap_ay;
  logic [NUM_ASTEROIDS-1:0]    snap_av;

  logic          chk_hit, chk_valid;
  logic [TW-1:0] chk_tag;
  logic [BW-1:0] tag_bi;
  logic [AW-1:0] tag_aj;

  assign busy   = (state == SCAN) || (state == DRAIN);
  assign done   = (state == DONE);
  assign tag_bi = chk_tag[AW +: BW];
  assign tag_aj = chk_tag[AW-1:0];

  // Snapshot is data-only; it is reloaded on every accepted start.
  always_ff @(posedge clock) begin
    if (state == IDLE && start && !reset) begin
      snap_bx <= bullet_x;
      snap_by <= bullet_y;
      snap_bv <= bullet_valid;
      snap_ax <= ast_x;
      snap_ay <= ast_y;
      snap_av <= ast_valid;
    end
  end

  pair_hit_checker #(
    .XW       (XW),
    .YW       (YW),
    .AST_SIZE (AST_SIZE),
    .TW       (TW)
  ) u_checker (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (state == SCAN),
    .bx        (snap_bx[bi*XW +: XW]),
    .by        (snap_by[bi*YW +: YW]),
    .bvalid    (snap_bv[bi]),
    .ax        (snap_ax[aj*XW +: XW]),
    .ay        (snap_ay[aj*YW +: YW]),
    .avalid    (snap_av[aj]),
    .in_tag    ({bi, aj}),
    .hit       (chk_hit),
    .out_valid (chk_valid),
    .tag       (chk_tag)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      bi         <= '0;
      aj         <= '0;
      bullet_hit <= '0;
      ast_hit    <= '0;
      hit_count  <= '0;
    end else begin
      if (chk_valid && chk_hit) begin
        bullet_hit[tag_bi] <= 1'b1;
        ast_hit[tag_aj]    <= 1'b1;
        hit_count          <= hit_count + HCW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            bullet_hit <= '0;
            ast_hit    <= '0;
            hit_count  <= '0;
            bi         <= '0;
            aj         <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (aj == AJ_LAST) begin
            aj <= '0;
            if (bi == BI_LAST) begin
              bi    <= '0;
              state <= DRAIN;
            end else begin
              bi <= bi + BW'(1);
            end
          end else begin
            aj <= aj + AW'(1);
          end
        end
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed scoreboard bench: each start pushes hand-computed results and the done cycle;
// a monitor pops and compares whenever done is presented.
module tb_collision_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] bullet_x;
  logic [55:0] bullet_y;
  logic [7:0]  bullet_valid;
  logic [63:0] ast_x;
  logic [55:0] ast_y;
  logic [7:0]  ast_valid;
  logic        busy, done;
  logic [7:0]  bullet_hit, ast_hit;
  logic [6:0]  hit_count;

  logic [7:0] bx [8];
  logic [6:0] by [8];
  logic [7:0] ax [8];
  logic [6:0] ay [8];

  typedef struct {
    logic [7:0] bh;
    logic [7:0] ah;
    int         cnt;
    int         when;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   pc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) pc++;

  always_comb begin
    bullet_x = '0;
    bullet_y = '0;
    ast_x    = '0;
    ast_y    = '0;
    for (int i = 0; i < 8; i++) begin
      bullet_x[i*8 +: 8] = bx[i];
      bullet_y[i*7 +: 7] = by[i];
      ast_x[i*8 +: 8]    = ax[i];
      ast_y[i*7 +: 7]    = ay[i];
    end
  end

  collision_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bullet_valid (bullet_valid),
    .ast_x        (ast_x),
    .ast_y        (ast_y),
    .ast_valid    (ast_valid),
    .busy         (busy),
    .done         (done),
    .bullet_hit   (bullet_hit),
    .ast_hit      (ast_hit),
    .hit_count    (hit_count)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at pc %0d", name, act, act, req, req, pc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          last_exp = exp_q.pop_front();
          chk("done_cycle", pc, last_exp.when);
          chk("bullet_hit", int'(bullet_hit), int'(last_exp.bh));
          chk("ast_hit", int'(ast_hit), int'(last_exp.ah));
          chk("hit_count", int'(hit_count), last_exp.cnt);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i < 8; i++) begin
      bx[i] = 8'd0; by[i] = 7'd0; ax[i] = 8'd0; ay[i] = 7'd0;
    end
    bullet_valid = 8'h00;
    ast_valid    = 8'h00;
  endtask

  // Leaves the bench at the negedge of cycle 1 (start accepted at the end of cycle 0).
  task automatic do_start(input bit push, input logic [7:0] ebh, input logic [7:0] eah, input int ecnt);
    exp_t e;
    @(negedge clock);
    start = 1'b1;
    if (push) begin
      e.bh = ebh; e.ah = eah; e.cnt = ecnt; e.when = pc + 66;
      exp_q.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_results();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 1, 0);
      exp_q.delete();
    end
    repeat (3) @(negedge clock);
    chk("stable_bullet_hit", int'(bullet_hit), int'(last_exp.bh));
    chk("stable_hit_count", int'(hit_count), last_exp.cnt);
  endtask

  task automatic cfg_single();
    clear_cfg();
    bx[0] = 8'd10; by[0] = 7'd20; bullet_valid = 8'h01;
    ax[3] = 8'd8;  ay[3] = 7'd18; ast_valid    = 8'h08;
  endtask

  task automatic cfg_two_on_five();
    clear_cfg();
    ax[5] = 8'd100; ay[5] = 7'd60;  ast_valid = 8'h20;
    bx[2] = 8'd101; by[2] = 7'd61;
    bx[6] = 8'd107; by[6] = 7'd67;  bullet_valid = 8'h44;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    clear_cfg();
    bx[1] = 8'd33; by[1] = 7'd44; bullet_valid = 8'hff; ast_valid = 8'hff;

    // 1: reset with arbitrary inputs and start held high
    repeat (2) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bullet_hit", int'(bullet_hit), 0);
    chk("rst_ast_hit", int'(ast_hit), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    reset = 1'b0;
    start = 1'b0;

    // 2: single hit, full timing profile
    cfg_single();
    do_start(1, 8'h01, 8'h08, 1);
    chk("busy_cycle1", int'(busy), 1);
    repeat (64) @(negedge clock);
    chk("busy_cycle65", int'(busy), 1);
    chk("done_cycle65", int'(done), 0);
    wait_results();

    // 3: box edges in x and y, plus the bottom-right corner asteroid
    clear_cfg();
    ax[0] = 8'd40;  ay[0] = 7'd40;
    ax[1] = 8'd156; ay[1] = 7'd112;
    ast_valid = 8'h03;
    bx[0] = 8'd47;  by[0] = 7'd40;
    bx[1] = 8'd48;  by[1] = 7'd40;
    bx[2] = 8'd39;  by[2] = 7'd40;
    bx[3] = 8'd159; by[3] = 7'd119;
    bx[4] = 8'd40;  by[4] = 7'd47;
    bx[5] = 8'd40;  by[5] = 7'd48;
    bullet_valid = 8'h3f;
    do_start(1, 8'h19, 8'h03, 3);
    wait_results();

    // 4a: overlapping geometry but invalid slots
    clear_cfg();
    bx[0] = 8'd10; by[0] = 7'd20; ax[0] = 8'd8;  ay[0] = 7'd18;
    bx[1] = 8'd50; by[1] = 7'd50; ax[1] = 8'd48; ay[1] = 7'd48;
    bullet_valid = 8'h02;
    ast_valid    = 8'h01;
    do_start(1, 8'h00, 8'h00, 0);
    wait_results();

    // 4b: two bullets on asteroid 5
    cfg_two_on_five();
    do_start(1, 8'h44, 8'h20, 2);
    wait_results();

    // 5: restart and coordinate changes mid-scan are ignored
    cfg_single();
    do_start(1, 8'h01, 8'h08, 1);
    repeat (9) @(negedge clock);
    start = 1'b1;
    bx[0] = 8'd100; by[0] = 7'd100;
    ax[3] = 8'd0;   ay[3] = 7'd0;
    bx[1] = 8'd2;   by[1] = 7'd2;
    bullet_valid = 8'hff;
    ast_valid    = 8'hff;
    @(negedge clock);
    start = 1'b0;
    wait_results();

    // 6: reset at cycle 30 abandons the scan without a done pulse
    cfg_single();
    do_start(0, 8'h00, 8'h00, 0);
    repeat (29) @(negedge clock);
    chk("midscan_hit_seen", int'(bullet_hit), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bullet_hit", int'(bullet_hit), 0);
    chk("abort_ast_hit", int'(ast_hit), 0);
    chk("abort_hit_count", int'(hit_count), 0);
    reset = 1'b0;
    repeat (80) @(negedge clock);
    chk("abort_stays_idle", int'(busy), 0);
    cfg_two_on_five();
    do_start(1, 8'h44, 8'h20, 2);
    wait_results();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
